// File: rtl/game_round_ctrl.sv
// rtl/game_round_ctrl.sv - reaction-time game round sequencer
// Drives the ms timer through random wait, GO window and result; tracks best score.
module game_round_ctrl #(
  parameter int MAX_MS      = 2047,
  parameter int ROUND_MS    = 1000,
  parameter int MIN_WAIT_MS = 500,
  parameter int WAIT_MASK   = 1023,
  localparam int W          = $clog2(MAX_MS)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start_btn,
  input  logic         i_hit_btn,
  input  logic         i_best_clr,
  output logic         o_timer_stop,
  output logic         o_timer_enable,
  output logic [W-1:0] o_timer_start_value,
  input  logic [W-1:0] i_timer_value,
  input  logic         i_game_over,
  output logic         o_led_go,
  output logic         o_result_valid,
  output logic [W-1:0] o_reaction_ms,
  output logic         o_false_start,
  output logic         o_timeout,
  output logic [W-1:0] o_best_ms,
  output logic         o_new_best
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_WAIT = 3'd1,
    WAIT      = 3'd2,
    LOAD_GO   = 3'd3,
    GO        = 3'd4,
    RESULT    = 3'd5
  } state_t;

  localparam logic [W-1:0] ALL_ONES = '1;
  localparam logic [W-1:0] C_ROUND  = W'(ROUND_MS);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [15:0]  r_lfsr;
  logic         r_start_q;
  logic         r_hit_q;
  logic [W-1:0] r_delay;
  logic [W-1:0] r_reaction;
  logic [W-1:0] r_best;
  logic         r_false_start;
  logic         r_timeout;
  logic         r_new_best;

  logic         w_start_edge;
  logic         w_hit_edge;
  logic         w_lfsr_fb;
  logic [W-1:0] w_delay;
  logic         w_latch_delay;
  logic         w_res_false;
  logic         w_res_hit;
  logic         w_res_timeout;
  logic         w_best_clr;

  assign w_start_edge = i_start_btn & ~r_start_q;
  assign w_hit_edge   = i_hit_btn & ~r_hit_q;
  assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_delay      = W'(MIN_WAIT_MS) + (r_lfsr[W-1:0] & W'(WAIT_MASK));

  // History regs reset high so a button held through reset yields no edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_start_q <= 1'b1;
      r_hit_q   <= 1'b1;
      r_lfsr    <= 16'hACE1;
    end else begin
      r_start_q <= i_start_btn;
      r_hit_q   <= i_hit_btn;
      r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_latch_delay = 1'b0;
    w_res_false   = 1'b0;
    w_res_hit     = 1'b0;
    w_res_timeout = 1'b0;
    w_best_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        w_best_clr = i_best_clr;
        if (w_start_edge) begin
          w_latch_delay = 1'b1;
          w_state_nxt   = LOAD_WAIT;
        end
      end
      LOAD_WAIT: w_state_nxt = WAIT;
      WAIT: begin
        // A hit coinciding with game_over still counts as a false start.
        if (w_hit_edge) begin
          w_res_false = 1'b1;
          w_state_nxt = RESULT;
        end else if (i_game_over) begin
          w_state_nxt = LOAD_GO;
        end
      end
      LOAD_GO: w_state_nxt = GO;
      GO: begin
        if (w_hit_edge) begin
          w_res_hit   = 1'b1;
          w_state_nxt = RESULT;
        end else if (i_game_over) begin
          w_res_timeout = 1'b1;
          w_state_nxt   = RESULT;
        end
      end
      RESULT: begin
        w_best_clr = i_best_clr;
        if (w_start_edge) begin
          w_latch_delay = 1'b1;
          w_state_nxt   = LOAD_WAIT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_delay       <= '0;
      r_reaction    <= '0;
      r_best        <= ALL_ONES;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
      r_new_best    <= 1'b0;
    end else begin
      if (w_latch_delay) begin
        r_delay       <= w_delay;
        r_false_start <= 1'b0;
        r_timeout     <= 1'b0;
        r_new_best    <= 1'b0;
      end
      if (w_res_false) begin
        r_reaction    <= '0;
        r_false_start <= 1'b1;
        r_timeout     <= 1'b0;
        r_new_best    <= 1'b0;
      end
      if (w_res_hit) begin
        r_reaction    <= i_timer_value;
        r_false_start <= 1'b0;
        r_timeout     <= 1'b0;
        if (i_timer_value < r_best) begin
          r_best     <= i_timer_value;
          r_new_best <= 1'b1;
        end else begin
          r_new_best <= 1'b0;
        end
      end
      if (w_res_timeout) begin
        r_reaction    <= C_ROUND;
        r_false_start <= 1'b0;
        r_timeout     <= 1'b1;
        r_new_best    <= 1'b0;
      end
      if (w_best_clr) r_best <= ALL_ONES;
    end
  end

  assign o_timer_stop        = (r_state != WAIT) && (r_state != GO);
  assign o_timer_enable      = (r_state == WAIT) || (r_state == GO);
  assign o_timer_start_value = (r_state == LOAD_WAIT) ? r_delay :
                               (r_state == LOAD_GO)   ? C_ROUND : '0;
  assign o_led_go            = (r_state == GO);
  assign o_result_valid      = (r_state == RESULT);
  assign o_reaction_ms       = r_reaction;
  assign o_false_start       = r_false_start;
  assign o_timeout           = r_timeout;
  assign o_best_ms           = r_best;
  assign o_new_best          = r_new_best;

endmodule

// File: tb/tb_game_round_ctrl.sv
// tb/tb_game_round_ctrl.sv - self-checking bench for game_round_ctrl
// Includes a ms timer model (10 clocks per ms) and a round-outcome scoreboard.
module tb_game_round_ctrl;

  localparam int W           = 11;
  localparam int CLKS_PER_MS = 10;
  localparam int ROUND       = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_btn = 1'b0;
  logic         hit_btn = 1'b0;
  logic         best_clr = 1'b0;
  logic         timer_stop;
  logic         timer_enable;
  logic [W-1:0] timer_start_value;
  logic [W-1:0] timer_value;
  logic         game_over;
  logic         led_go;
  logic         result_valid;
  logic [W-1:0] reaction_ms;
  logic         false_start;
  logic         timeout;
  logic [W-1:0] best_ms;
  logic         new_best;

  game_round_ctrl #(
    .MAX_MS(2047), .ROUND_MS(ROUND), .MIN_WAIT_MS(5), .WAIT_MASK(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start_btn(start_btn), .i_hit_btn(hit_btn),
    .i_best_clr(best_clr), .o_timer_stop(timer_stop), .o_timer_enable(timer_enable),
    .o_timer_start_value(timer_start_value), .i_timer_value(timer_value),
    .i_game_over(game_over), .o_led_go(led_go), .o_result_valid(result_valid),
    .o_reaction_ms(reaction_ms), .o_false_start(false_start), .o_timeout(timeout),
    .o_best_ms(best_ms), .o_new_best(new_best)
  );

  always #5 clk = ~clk;

  // Millisecond timer: stop clears elapsed and loads the limit.
  logic [W-1:0] t_elapsed = '0;
  logic [W-1:0] t_limit = '0;
  int           t_pre = 0;
  always @(posedge clk) begin
    if (timer_stop) begin
      t_elapsed <= '0;
      t_pre     <= 0;
      t_limit   <= timer_start_value;
    end else if (timer_enable) begin
      if (t_pre == CLKS_PER_MS - 1) begin
        t_pre <= 0;
        if (t_elapsed < t_limit) t_elapsed <= t_elapsed + 1'b1;
      end else begin
        t_pre <= t_pre + 1;
      end
    end
  end
  assign timer_value = t_elapsed;
  assign game_over   = (t_elapsed >= t_limit);

  int n_checks = 0;
  int n_errors = 0;
  int m_best   = 2047;
  int m_react  = 0;
  int m_fs     = 0;
  int m_to     = 0;
  int m_nb     = 0;
  bit cmp_en   = 1'b0;
  bit go_seen  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (led_go) go_seen = 1'b1;
    if (cmp_en) begin
      chk("best_ms", best_ms, m_best);
      if (!rst_n) begin
        chk("rst_stop", timer_stop, 1);
        chk("rst_led_go", led_go, 0);
        chk("rst_valid", result_valid, 0);
      end else begin
        chk("stop_vs_enable", timer_stop, !timer_enable);
        chk("go_and_valid", led_go & result_valid, 0);
        if (result_valid) begin
          chk("res_reaction", reaction_ms, m_react);
          chk("res_false_start", false_start, m_fs);
          chk("res_timeout", timeout, m_to);
          chk("res_new_best", new_best, m_nb);
          chk("res_stop", timer_stop, 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    go_seen = 1'b0;
  endtask

  function automatic bit cond(input int mode, input int v);
    case (mode)
      0:       return led_go && (timer_value == v);
      1:       return timer_enable && !led_go && (timer_value == v);
      2:       return led_go && game_over;
      3:       return result_valid;
      default: return led_go;
    endcase
  endfunction

  task automatic wait_cond(input int mode, input int v, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (cond(mode, v)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(name, ok, 1);
  endtask

  // Valid hit in GO: the model scores it from the timer value seen now.
  task automatic hit_in_go();
    m_react = timer_value;
    m_fs    = 0;
    m_to    = 0;
    m_nb    = (int'(timer_value) < m_best) ? 1 : 0;
    hit_btn = 1'b1;
    tick();
    hit_btn = 1'b0;
    if (m_nb == 1) m_best = timer_value;
  endtask

  task automatic pulse_clr(input bit allowed);
    best_clr = 1'b1;
    tick();
    best_clr = 1'b0;
    if (allowed) m_best = 2047;
  endtask

  initial begin
    bit bad;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("reset_stop", timer_stop, 1);
    chk("reset_enable", timer_enable, 0);
    chk("reset_start_value", timer_start_value, 0);
    chk("reset_best", best_ms, 2047);
    chk("reset_valid", result_valid, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    start_round();
    wait_cond(0, 7, "wait_r1");
    hit_in_go();
    chk("r1_valid", result_valid, 1);
    chk("r1_reaction", reaction_ms, 7);
    chk("r1_best", best_ms, 7);
    chk("r1_new_best", new_best, 1);

    repeat (3) tick();
    start_round();
    wait_cond(0, 9, "wait_r2");
    hit_in_go();
    chk("r2_reaction", reaction_ms, 9);
    chk("r2_best", best_ms, 7);
    chk("r2_new_best", new_best, 0);

    start_round();
    wait_cond(0, 7, "wait_r3");
    hit_in_go();
    chk("r3_best", best_ms, 7);
    chk("r3_new_best", new_best, 0);

    start_round();
    wait_cond(1, 2, "wait_fs");
    m_react = 0; m_fs = 1; m_to = 0; m_nb = 0;
    hit_btn = 1'b1;
    tick();
    hit_btn = 1'b0;
    chk("fs_flag", false_start, 1);
    chk("fs_reaction", reaction_ms, 0);
    chk("fs_best", best_ms, 7);
    repeat (2) tick();
    chk("fs_no_go", go_seen, 0);

    start_round();
    m_react = ROUND; m_fs = 0; m_to = 1; m_nb = 0;
    wait_cond(3, 0, "wait_timeout");
    tick();
    chk("to_flag", timeout, 1);
    chk("to_reaction", reaction_ms, 20);
    hit_btn = 1'b1;
    tick();
    hit_btn = 1'b0;
    repeat (2) tick();
    chk("to_hit_ignored_valid", result_valid, 1);
    chk("to_hit_ignored_flag", timeout, 1);

    pulse_clr(1'b1);
    tick();
    chk("clr_in_result", best_ms, 2047);

    start_round();
    wait_cond(2, 0, "wait_coincide");
    hit_in_go();
    chk("co_reaction", reaction_ms, 20);
    chk("co_timeout", timeout, 0);
    chk("co_new_best", new_best, 1);

    start_round();
    wait_cond(4, 0, "wait_go_clr");
    pulse_clr(1'b0);
    tick();
    chk("clr_in_go", best_ms, 20);
    chk("clr_in_go_led", led_go, 1);

    rst_n = 1'b0;
    m_best = 2047;
    #1;
    chk("rst_mid_stop", timer_stop, 1);
    chk("rst_mid_led", led_go, 0);
    chk("rst_mid_best", best_ms, 2047);
    start_btn = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (timer_enable || result_valid || !timer_stop) bad = 1'b1;
    end
    chk("held_start_idle", bad, 0);
    start_btn = 1'b0;
    repeat (2) tick();

    start_round();
    wait_cond(0, 3, "wait_final");
    hit_in_go();
    chk("final_reaction", reaction_ms, 3);
    chk("final_best", best_ms, 3);
    chk("final_new_best", new_best, 1);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
